d_mem_responder: RTL and testbench
==================================

D_MEM_RESPONDER -- requirements
Module: d_mem_responder

Interface
REQ-001 Parameter DEPTH, default 4096, storage size in 32-bit words; SHALL be a power of two.
REQ-002 Parameter ADDR_W, default 12, word-address width; SHALL satisfy 2**ADDR_W >= DEPTH.
REQ-003 Parameter INIT_CLEAR, default 1, 1 = zero-fill sweep after reset, 0 = skip the sweep.
REQ-004 Timing and reset SHALL be: one clock; reset is synchronous and active-low.
REQ-005 Port CLK  in  1  clock; all state SHALL update on its rising edge.
REQ-006 Port RSTn  in  1  synchronous active-low reset.
REQ-007 Port D_MEM_CSN  in  1  chip select, active low.
REQ-008 Port D_MEM_WEN  in  1  write enable, active low; 1 = read.
REQ-009 Port D_MEM_ADDR  in  ADDR_W  word address.
REQ-010 Port D_MEM_BE  in  4  byte enables; bit i covers bits 8i+7:8i.
REQ-011 Port D_MEM_DI  in  32  write data from the initiator.
REQ-012 Port D_MEM_DOUT  out  32  registered read data to the initiator.
REQ-013 Port D_MEM_RDY  out  1  1 = requests are accepted; 0 = init sweep in progress.

Function
REQ-014 The FSM SHALL have states INIT and SERVE; RDY SHALL be 1 only in SERVE.
REQ-015 INIT SHALL write zero to word ptr, one word per cycle, with ptr running 0..DEPTH-1; after ptr = DEPTH-1 it SHALL enter SERVE on the next cycle; with INIT_CLEAR=0 the first cycle after reset SHALL enter SERVE.
REQ-016 Requests during INIT SHALL be ignored: no write, DOUT holds, no stats update.
REQ-017 Read (CSN=0, WEN=1) sampled at edge N SHALL load DOUT with mem[ADDR] at edge N, visible to the initiator for all of cycle N+1; BE SHALL be ignored on reads.
REQ-018 Write (CSN=0, WEN=0) at edge N SHALL update only the bytes whose BE bit is 1; DOUT SHALL hold its previous value.
REQ-019 A write with BE=0000 SHALL leave memory unchanged.
REQ-020 CSN=1 SHALL cause no access, and DOUT SHALL hold.
REQ-021 A read at edge N+1 of the address written at edge N SHALL return the merged new word.
REQ-022 An address >= DEPTH SHALL be reduced modulo DEPTH (low log2(DEPTH) bits).
REQ-023 Back-to-back requests on every cycle SHALL be accepted with no bubble.

Reset
REQ-024 RSTn=0 at a rising edge SHALL set DOUT=0, ptr=0, and state INIT (SERVE when INIT_CLEAR=0), and RDY=0.
REQ-025 Reset asserted mid-sweep or mid-access SHALL abort the operation and restart the sweep from 0; reset SHALL not itself clear the array except via the sweep.

Configuration
REQ-026 With macro DMEM_STATS_EN defined, the block SHALL add outputs RD_CNT[31:0] and WR_CNT[31:0].
REQ-027 RD_CNT and WR_CNT SHALL count accepted reads and writes in SERVE, including BE=0000 writes.
REQ-028 RD_CNT and WR_CNT SHALL saturate at 32'hFFFFFFFF and SHALL clear on reset.
REQ-029 Without DMEM_STATS_EN the ports and counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 Package dmem_pkg SHALL hold DATA_W=32, BE_W=4 and the state enum {INIT, SERVE}.
REQ-031 Sub-module dmem_init_sweep SHALL own ptr, the zero-write strobe and the done flag.
REQ-032 Byte merge, the array and DOUT SHALL reside in d_mem_responder.

Verification
REQ-033 Reset with INIT_CLEAR=1, DEPTH=16 -> RDY=0 for exactly 16 cycles, then 1; reading all 16 addresses returns 0.
REQ-034 Write ADDR=5, DI=32'hAABBCCDD, BE=1111, then write DI=32'h11223344, BE=0101 -> read ADDR=5 returns 32'hAA22CC44 one cycle later.
REQ-035 Write ADDR=3, then read ADDR=3 on the next cycle, then CSN=1 for 3 cycles -> DOUT shows the new word and holds it through the idle cycles.
REQ-036 DEPTH=16: write ADDR=18, read ADDR=2 -> the read returns the written data.
REQ-037 Assert reset at sweep ptr=7 -> DOUT=0, RDY=0, and the sweep restarts at 0 taking 16 more cycles.
REQ-038 With DMEM_STATS_EN: 3 reads, 2 writes (one BE=0000), 1 request during INIT -> RD_CNT=3, WR_CNT=2.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared widths and FSM state type for the data-memory responder.
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic {
    INIT,
    SERVE
  } state_t;

endpackage

// File: rtl/dmem_init_sweep.sv
// Post-reset zero-fill sweep: walks ptr over every word, strobes a zero
// write each cycle, and raises done once the array is clean.
module dmem_init_sweep
  import dmem_pkg::*;
#(
  parameter int DEPTH      = 4096,
  parameter int INIT_CLEAR = 1,
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [IDX_W-1:0] ptr,
  output logic             clr_we,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(DEPTH - 1);

  state_t state;

  // Sweep FSM: INIT clears one word per cycle, SERVE opens the port a cycle after the last word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if (INIT_CLEAR != 0) begin
        state  <= INIT;
        clr_we <= 1'b1;
      end else begin
        state  <= SERVE;
        clr_we <= 1'b0;
      end
      ptr  <= '0;
      done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (ptr == LAST_PTR) begin
            state  <= SERVE;
            clr_we <= 1'b0;
            done   <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          clr_we <= 1'b0;
          done   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/d_mem_responder.sv
// Single-port word-addressed data memory with byte enables and a
// registered read port. Optional access counters are enabled by defining
// the macro DMEM_STATS_EN.
module d_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH      = 4096,
  parameter int ADDR_W     = 12,
  parameter int INIT_CLEAR = 1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              D_MEM_CSN,
  input  logic              D_MEM_WEN,
  input  logic [ADDR_W-1:0] D_MEM_ADDR,
  input  logic [BE_W-1:0]   D_MEM_BE,
  input  logic [DATA_W-1:0] D_MEM_DI,
  output logic [DATA_W-1:0] D_MEM_DOUT,
  output logic              D_MEM_RDY
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]       RD_CNT,
  output logic [31:0]       WR_CNT
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  sweep_ptr;
  logic              sweep_we;
  logic              sweep_done;
  logic [IDX_W-1:0]  idx;
  logic              rd_acc;
  logic              wr_acc;
  logic              unused_addr;

  dmem_init_sweep #(
    .DEPTH      (DEPTH),
    .INIT_CLEAR (INIT_CLEAR)
  ) u_sweep (
    .clk    (CLK),
    .rst_n  (RSTn),
    .ptr    (sweep_ptr),
    .clr_we (sweep_we),
    .done   (sweep_done)
  );

  assign idx         = D_MEM_ADDR[IDX_W-1:0];
  assign unused_addr = ^D_MEM_ADDR;
  assign rd_acc      = sweep_done & ~D_MEM_CSN & D_MEM_WEN;
  assign wr_acc      = sweep_done & ~D_MEM_CSN & ~D_MEM_WEN;
  assign D_MEM_RDY   = sweep_done;

  // Array writes: sweep zeroes take the port during INIT, otherwise merge enabled bytes; reset aborts both.
  always_ff @(posedge CLK) begin
    if (RSTn) begin
      if (sweep_we) begin
        mem[sweep_ptr] <= '0;
      end else if (wr_acc) begin
        for (int i = 0; i < BE_W; i++) begin
          if (D_MEM_BE[i]) begin
            mem[idx][8*i +: 8] <= D_MEM_DI[8*i +: 8];
          end
        end
      end
    end
  end

  // Registered read data: loads only on an accepted read and holds otherwise.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      D_MEM_DOUT <= '0;
    end else if (rd_acc) begin
      D_MEM_DOUT <= mem[idx];
    end
  end

`ifdef DMEM_STATS_EN
  // Saturating counters of accepted reads and writes (empty-mask writes still count).
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      RD_CNT <= '0;
      WR_CNT <= '0;
    end else begin
      if (rd_acc && (RD_CNT != '1)) begin
        RD_CNT <= RD_CNT + 1'b1;
      end
      if (wr_acc && (WR_CNT != '1)) begin
        WR_CNT <= WR_CNT + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_d_mem_responder.sv
// Scoreboard bench for d_mem_responder (DEPTH=16); build with DMEM_STATS_EN
// defined to also check the access counters.
module tb_d_mem_responder;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 5;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        csn   = 1'b1;
  logic        wen   = 1'b1;
  logic [4:0]  addr  = '0;
  logic [3:0]  be    = '0;
  logic [31:0] di    = '0;
  logic [31:0] dout;
  logic        rdy;
`ifdef DMEM_STATS_EN
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
`endif

  int total   = 0;
  int bad     = 0;
  int cyc     = 0;
  int tag     = 0;
  int exp_rd  = 0;
  int exp_wr  = 0;
  bit serving = 1'b0;

  typedef struct {
    logic [31:0] exp;
    int          due;
    int          tag;
  } sb_t;

  sb_t sb[$];
  sb_t mon_entry;

  d_mem_responder #(
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W),
    .INIT_CLEAR (1)
  ) dut (
    .CLK        (clk),
    .RSTn       (rst_n),
    .D_MEM_CSN  (csn),
    .D_MEM_WEN  (wen),
    .D_MEM_ADDR (addr),
    .D_MEM_BE   (be),
    .D_MEM_DI   (di),
    .D_MEM_DOUT (dout),
    .D_MEM_RDY  (rdy)
`ifdef DMEM_STATS_EN
    ,
    .RD_CNT     (rd_cnt),
    .WR_CNT     (wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%08h expected=%08h", name, got, exp);
    end
  endtask

  // Drive one request for one clock; reads accepted while serving queue their expected word.
  task automatic applyStimulus(input logic c, input logic w, input logic [4:0] a,
                               input logic [3:0] b, input logic [31:0] d, input logic [31:0] exp_word);
    csn  = c;
    wen  = w;
    addr = a;
    be   = b;
    di   = d;
    if (!c && w && serving) begin
      sb.push_back('{exp_word, cyc + 1, tag});
      tag++;
      exp_rd++;
    end
    if (!c && !w && serving) begin
      exp_wr++;
    end
    @(posedge clk);
    #1;
    csn = 1'b1;
  endtask

  // Release reset with one request during INIT and count cycles until ready.
  task automatic waitSweep(input string name);
    int n;
    n     = 0;
    rst_n = 1'b1;
    csn   = 1'b0;
    wen   = 1'b1;
    addr  = 5'd0;
    do begin
      @(posedge clk);
      #1;
      csn = 1'b1;
      n++;
    end while (!rdy && n < 40);
    checkOutput(name, 32'(n), 32'd16);
    checkOutput({name, "_dout"}, dout, 32'h0);
    serving = 1'b1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() > 0 && w < 10) begin
      @(posedge clk);
      #1;
      w++;
    end
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: compare read data in the cycle it becomes visible.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_entry = sb.pop_front();
      checkOutput($sformatf("read%0d", mon_entry.tag), dout, mon_entry.exp);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_dout", dout, 32'h0);
    checkOutput("reset_rdy", {31'b0, rdy}, 32'h0);
    waitSweep("sweep_cycles");

    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b0, 1'b1, 5'(a), 4'hF, 32'h0, 32'h0);
    end

    applyStimulus(1'b0, 1'b0, 5'd5, 4'hF, 32'hAABBCCDD, 32'h0);
    applyStimulus(1'b0, 1'b0, 5'd5, 4'b0101, 32'h11223344, 32'h0);
    applyStimulus(1'b0, 1'b1, 5'd5, 4'hF, 32'h0, 32'hAA22CC44);

    applyStimulus(1'b0, 1'b0, 5'd5, 4'h0, 32'hFFFFFFFF, 32'h0);
    checkOutput("dout_hold_on_write", dout, 32'hAA22CC44);
    applyStimulus(1'b0, 1'b1, 5'd5, 4'hF, 32'h0, 32'hAA22CC44);

    applyStimulus(1'b0, 1'b0, 5'd3, 4'hF, 32'h12345678, 32'h0);
    applyStimulus(1'b0, 1'b1, 5'd3, 4'hF, 32'h0, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 5'd5, 4'hF, 32'h0, 32'h0);
      checkOutput($sformatf("idle_hold%0d", i), dout, 32'h12345678);
    end

    applyStimulus(1'b0, 1'b0, 5'd18, 4'hF, 32'hCAFEF00D, 32'h0);
    applyStimulus(1'b0, 1'b1, 5'd2, 4'hF, 32'h0, 32'hCAFEF00D);
    applyStimulus(1'b0, 1'b1, 5'd18, 4'hF, 32'h0, 32'hCAFEF00D);

    applyStimulus(1'b0, 1'b0, 5'd7, 4'hF, 32'h01020304, 32'h0);
    applyStimulus(1'b0, 1'b1, 5'd7, 4'hF, 32'h0, 32'h01020304);
    applyStimulus(1'b0, 1'b0, 5'd7, 4'b1000, 32'hA0B0C0D0, 32'h0);
    applyStimulus(1'b0, 1'b1, 5'd7, 4'h0, 32'h0, 32'hA0020304);
    drain();

`ifdef DMEM_STATS_EN
    checkOutput("rd_cnt", rd_cnt, 32'(exp_rd));
    checkOutput("wr_cnt", wr_cnt, 32'(exp_wr));
`endif

    csn     = 1'b0;
    wen     = 1'b0;
    addr    = 5'd9;
    be      = 4'hF;
    di      = 32'h55555555;
    rst_n   = 1'b0;
    serving = 1'b0;
    exp_rd  = 0;
    exp_wr  = 0;
    @(posedge clk);
    #1;
    csn = 1'b1;
    checkOutput("rst_access_dout", dout, 32'h0);
    checkOutput("rst_access_rdy", {31'b0, rdy}, 32'h0);
`ifdef DMEM_STATS_EN
    checkOutput("rst_rd_cnt", rd_cnt, 32'h0);
    checkOutput("rst_wr_cnt", wr_cnt, 32'h0);
`endif

    rst_n = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    checkOutput("mid_sweep_rdy", {31'b0, rdy}, 32'h0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_sweep_rst_dout", dout, 32'h0);
    checkOutput("mid_sweep_rst_rdy", {31'b0, rdy}, 32'h0);
    waitSweep("resweep_cycles");

    applyStimulus(1'b0, 1'b1, 5'd5, 4'hF, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 5'd3, 4'hF, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 5'd7, 4'hF, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 5'd9, 4'hF, 32'h0, 32'h0);
    drain();

`ifdef DMEM_STATS_EN
    checkOutput("rd_cnt_after_resweep", rd_cnt, 32'(exp_rd));
    checkOutput("wr_cnt_after_resweep", wr_cnt, 32'(exp_wr));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
